// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered strobes, syncs and blanking.
// Define VIDEO_TIMING_INTERLACE_EN to enable the interlaced NTSC field mode.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int I_H_TOTAL  = 1588,
  parameter int I_H_ACTIVE = 1280,
  parameter int I_HS_START = 1300,
  parameter int I_HS_LEN   = 117,
  parameter int I_V_ACTIVE = 240,
  parameter int I_VS_START = 244,
  parameter int I_VS_LEN   = 3,
  parameter int I_V_TOTAL  = 263
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interlaced,
  output logic        display_next_pixel,
  output logic        display_next_line,
  output logic        display_next_frame,
  output logic        display_current_field,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank,
  output logic [10:0] h_count,
  output logic [9:0]  v_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        h_last, v_last;
  logic        h_act, v_act;
  logic        hs_on, vs_on;
  logic        field_w;

  logic        pix_q, line_q, frame_q, fld_q;
  logic        hs_n_q, vs_n_q, blank_q;
  logic [10:0] hc_q;
  logic [9:0]  vc_q;

`ifdef VIDEO_TIMING_INTERLACE_EN
  localparam logic [10:0] I_H_LAST  = 11'(I_H_TOTAL - 1);
  localparam logic [10:0] I_H_ACT   = 11'(I_H_ACTIVE);
  localparam logic [10:0] I_HS_BEG  = 11'(I_HS_START);
  localparam logic [10:0] I_HS_END  = 11'(I_HS_START + I_HS_LEN);
  localparam logic [9:0]  I_V_LAST0 = 10'(I_V_TOTAL - 1);
  localparam logic [9:0]  I_V_LAST1 = 10'(I_V_TOTAL - 2);
  localparam logic [9:0]  I_V_ACT   = 10'(I_V_ACTIVE);
  localparam logic [9:0]  I_VS_BEG  = 10'(I_VS_START);
  localparam logic [9:0]  I_VS_END  = 10'(I_VS_START + I_VS_LEN);

  logic mode_q, mode_d;
  logic field_q, field_d;
`endif

  always_comb begin
    h_last = (h_q == H_LAST);
    h_act  = (h_q < H_ACT);
    hs_on  = (h_q >= HS_BEG) && (h_q < HS_END);
    v_last = (v_q == V_LAST);
    v_act  = (v_q < V_ACT);
    vs_on  = (v_q >= VS_BEG) && (v_q < VS_END);
`ifdef VIDEO_TIMING_INTERLACE_EN
    if (mode_q) begin
      h_last = (h_q == I_H_LAST);
      h_act  = (h_q < I_H_ACT);
      hs_on  = (h_q >= I_HS_BEG) && (h_q < I_HS_END);
      // field 1 is one line shorter than field 0
      v_last = (v_q == (field_q ? I_V_LAST1 : I_V_LAST0));
      v_act  = (v_q < I_V_ACT);
      vs_on  = (v_q >= I_VS_BEG) && (v_q < I_VS_END);
    end
`endif
  end

  always_comb begin
    h_d = h_last ? 11'd0 : h_q + 11'd1;
    v_d = v_q;
    if (h_last) begin
      v_d = v_last ? 10'd0 : v_q + 10'd1;
    end
  end

`ifdef VIDEO_TIMING_INTERLACE_EN
  // mode only changes on frame boundaries; field restarts at 0 on entry
  always_comb begin
    mode_d  = mode_q;
    field_d = field_q;
    if (h_last && v_last) begin
      mode_d  = interlaced;
      field_d = (interlaced && mode_q) ? ~field_q : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      field_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      field_q <= field_d;
    end
  end

  assign field_w = field_q;
`else
  logic unused_interlaced;
  assign unused_interlaced = interlaced;
  assign field_w = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= 11'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fld_q   <= 1'b0;
      hs_n_q  <= 1'b1;
      vs_n_q  <= 1'b1;
      blank_q <= 1'b0;
      hc_q    <= 11'd0;
      vc_q    <= 10'd0;
    end else begin
      pix_q   <= h_act;
      line_q  <= h_last;
      frame_q <= h_last & v_last;
      fld_q   <= field_w;
      hs_n_q  <= ~hs_on;
      vs_n_q  <= ~vs_on;
      blank_q <= ~(h_act & v_act);
      hc_q    <= h_q;
      vc_q    <= v_q;
    end
  end

  assign display_next_pixel    = pix_q;
  assign display_next_line     = line_q;
  assign display_next_frame    = frame_q;
  assign display_current_field = fld_q;
  assign hsync_n               = hs_n_q;
  assign vsync_n               = vs_n_q;
  assign blank                 = blank_q;
  assign h_count               = hc_q;
  assign v_count               = vc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: scaled-geometry instance with scoreboard and
// vector table, plus a default-geometry instance for full VGA line timing.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int IHT = 100, IHA = 80, IHS = 84, IHL = 6;
  localparam int IVA = 10, IVS = 12, IVL = 2, IVT = 15;
`ifdef VIDEO_TIMING_INTERLACE_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, interlaced;

  logic pix, line, frame, fld, hs_n, vs_n, blank;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic b_pix, b_line, b_frame, b_fld, b_hs_n, b_vs_n, b_blank;
  logic [10:0] b_hc;
  logic [9:0]  b_vc;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .I_H_TOTAL(IHT), .I_H_ACTIVE(IHA),
    .I_HS_START(IHS), .I_HS_LEN(IHL),
    .I_V_ACTIVE(IVA), .I_VS_START(IVS),
    .I_VS_LEN(IVL), .I_V_TOTAL(IVT)
  ) u_dut (
    .clk(clk), .rst(rst), .interlaced(interlaced),
    .display_next_pixel(pix),
    .display_next_line(line),
    .display_next_frame(frame),
    .display_current_field(fld),
    .hsync_n(hs_n), .vsync_n(vs_n), .blank(blank),
    .h_count(hc), .v_count(vc)
  );

  video_timing_gen u_vga (
    .clk(clk), .rst(rst), .interlaced(interlaced),
    .display_next_pixel(b_pix),
    .display_next_line(b_line),
    .display_next_frame(b_frame),
    .display_current_field(b_fld),
    .hsync_n(b_hs_n), .vsync_n(b_vs_n), .blank(b_blank),
    .h_count(b_hc), .v_count(b_vc)
  );

  typedef struct packed {
    logic pix, line, frame, fld, hs_n, vs_n, blank;
    logic [10:0] h;
    logic [9:0]  v;
  } obs_t;

  typedef struct {
    int f, h, v;
    logic pix, line, frame, hs_n, vs_n, blank;
  } vec_t;

  localparam obs_t RST_OBS = '{1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b0, 11'd0, 10'd0};

  int tests = 0;
  int fails = 0;
  obs_t exp_q[$];
  bit sb_en = 1'b0;
  int m_h, m_v;
  bit m_mode, m_field;
  int tcyc;

  function automatic obs_t obs_s();
    return '{pix, line, frame, fld, hs_n, vs_n, blank, hc, vc};
  endfunction

  function automatic obs_t obs_b();
    return '{b_pix, b_line, b_frame, b_fld, b_hs_n, b_vs_n,
      b_blank, b_hc, b_vc};
  endfunction

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic chk_obs(string name, obs_t a, obs_t e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic int f_ht();
    return m_mode ? IHT : HT;
  endfunction

  function automatic int f_vt();
    if (!m_mode) return VT;
    return m_field ? IVT - 1 : IVT;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int ha, hb, hl, va, vb, vl;
    ha = m_mode ? IHA : HA;
    hb = m_mode ? IHS : HA + HF;
    hl = m_mode ? IHL : HS;
    va = m_mode ? IVA : VA;
    vb = m_mode ? IVS : VA + VF;
    vl = m_mode ? IVL : VS;
    o.pix   = m_h < ha;
    o.line  = m_h == f_ht() - 1;
    o.frame = o.line && (m_v == f_vt() - 1);
    o.fld   = m_field;
    o.hs_n  = !(m_h >= hb && m_h < hb + hl);
    o.vs_n  = !(m_v >= vb && m_v < vb + vl);
    o.blank = (m_h >= ha) || (m_v >= va);
    o.h     = 11'(m_h);
    o.v     = 10'(m_v);
    return o;
  endfunction

  task automatic model_step();
    bit nm;
    if (m_h == f_ht() - 1) begin
      m_h = 0;
      if (m_v == f_vt() - 1) begin
        m_v = 0;
        nm = IL & interlaced;
        m_field = (nm && m_mode) ? !m_field : 1'b0;
        m_mode = nm;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
  endtask

  always @(posedge clk) begin
    if (!rst && sb_en) begin
      exp_q.push_back(model_out());
      model_step();
    end
  end

  always @(negedge clk) begin
    if (!rst && sb_en && exp_q.size() > 0) begin
      chk_obs("scoreboard", obs_s(), exp_q.pop_front());
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) tcyc <= 0;
    else tcyc <= tcyc + 1;
  end

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    m_h = 0;
    m_v = 0;
    m_mode = 1'b0;
    m_field = 1'b0;
  endtask

  task automatic wait_for(bit frm, string name);
    int k = 0;
    while (!(frm ? frame : line) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) chk(name, 0, 1);
  endtask

  // starts on the h=0 sample of a line
  task automatic measure_line(output int per, output int pc);
    per = 1;
    pc = int'(pix);
    while (!line && per < 5000) begin
      @(negedge clk);
      per++;
      pc += int'(pix);
    end
  endtask

  // starts on the h=0 sample of a field; ends on h=0 of the next
  task automatic measure_field(output int lines, output int f_at,
                               output int f_after);
    int k = 0;
    lines = 0;
    while (!frame && k < 5000) begin
      @(negedge clk);
      k++;
      if (line) lines++;
    end
    f_at = int'(fld);
    @(negedge clk);
    f_after = int'(fld);
  endtask

  vec_t tbl[17];

  initial begin
    int per, pc, ln, fa, fb, p, g;
    int pixc, hsc, hs_first, hs_last, blc, nl, l_first, l_last;

    tbl[0]  = '{0,  0,  0, 1, 0, 0, 1, 1, 0};
    tbl[1]  = '{0, 63,  0, 1, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 64,  0, 0, 0, 0, 1, 1, 1};
    tbl[3]  = '{0, 67,  0, 0, 0, 0, 1, 1, 1};
    tbl[4]  = '{0, 68,  0, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{0, 75,  0, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{0, 76,  0, 0, 0, 0, 1, 1, 1};
    tbl[7]  = '{0, 79,  0, 0, 1, 0, 1, 1, 1};
    tbl[8]  = '{0, 10, 11, 1, 0, 0, 1, 1, 0};
    tbl[9]  = '{0, 10, 12, 1, 0, 0, 1, 1, 1};
    tbl[10] = '{0,  0, 13, 1, 0, 0, 1, 1, 1};
    tbl[11] = '{0,  0, 14, 1, 0, 0, 1, 0, 1};
    tbl[12] = '{0, 79, 15, 0, 1, 0, 1, 0, 1};
    tbl[13] = '{0,  0, 16, 1, 0, 0, 1, 1, 1};
    tbl[14] = '{0, 79, 18, 0, 1, 1, 1, 1, 1};
    tbl[15] = '{1,  0,  0, 1, 0, 0, 1, 1, 0};
    tbl[16] = '{1, 70,  3, 0, 0, 0, 0, 1, 1};

    interlaced = 1'b0;
    apply_reset();
    repeat (2) @(negedge clk);
    chk_obs("reset_small", obs_s(), RST_OBS);
    chk_obs("reset_vga", obs_b(), RST_OBS);
    sb_en = 1'b1;
    rst = 1'b0;

    // spot vectors on the scaled VGA raster, through the frame wrap
    foreach (tbl[i]) begin
      p = tbl[i].f * HT * VT + tbl[i].v * HT + tbl[i].h;
      g = 0;
      while (tcyc < p + 1 && g < 5000) begin
        @(negedge clk);
        g++;
      end
      chk_obs($sformatf("vec%0d", i), obs_s(),
        '{tbl[i].pix, tbl[i].line, tbl[i].frame, 1'b0,
          tbl[i].hs_n, tbl[i].vs_n, tbl[i].blank,
          11'(tbl[i].h), 10'(tbl[i].v)});
    end

    // mode request mid-frame: current frame keeps VGA timing
    interlaced = 1'b1;
    wait_for(1'b0, "wait_line");
    @(negedge clk);
    measure_line(per, pc);
    chk("line_period_pre_switch", per, HT);
    chk("pixels_pre_switch", pc, HA);
    wait_for(1'b1, "wait_frame");
    chk("field_at_switch_strobe", int'(fld), 0);
    @(negedge clk);
    chk("field_after_switch", int'(fld), 0);
    measure_line(per, pc);
    chk("line_period_post_switch", per, IL ? IHT : HT);
    chk("pixels_post_switch", pc, IL ? IHA : HA);

    // field lengths and field flag around frame strobes
    wait_for(1'b1, "wait_field_end");
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      measure_field(ln, fa, fb);
      chk($sformatf("field%0d_lines", i), ln,
        IL ? ((i % 2 == 0) ? IVT - 1 : IVT) : VT);
      chk($sformatf("field%0d_at_strobe", i), fa,
        IL ? ((i % 2 == 0) ? 1 : 0) : 0);
      chk($sformatf("field%0d_after_strobe", i), fb,
        IL ? ((i % 2 == 0) ? 0 : 1) : 0);
    end

    // asynchronous reset in the middle of a full-size line
    interlaced = 1'b0;
    g = 0;
    while (b_hc != 11'd300 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("reach_h300", int'(b_hc), 300);
    #2;
    apply_reset();
    #1;
    chk_obs("reset_mid_small", obs_s(), RST_OBS);
    chk_obs("reset_mid_vga", obs_b(), RST_OBS);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // full-size VGA horizontal timing over two lines after restart
    pixc = 0; hsc = 0; blc = 0; nl = 0;
    hs_first = -1; hs_last = -1; l_first = -1; l_last = -1;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (i == 0) chk_obs("vga_first_sample", obs_b(),
        '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 10'd0});
      if (i < 800) begin
        pixc += int'(b_pix);
        blc += int'(b_blank);
        if (!b_hs_n) begin
          hsc++;
          if (hs_first < 0) hs_first = i;
          hs_last = i;
        end
      end
      if (b_line) begin
        nl++;
        if (l_first < 0) l_first = i;
        l_last = i;
      end
    end
    chk("vga_pixels", pixc, 640);
    chk("vga_blank", blc, 160);
    chk("vga_hs_len", hsc, 96);
    chk("vga_hs_first", hs_first, 656);
    chk("vga_hs_last", hs_last, 751);
    chk("vga_line_first", l_first, 799);
    chk("vga_line_second", l_last, 1599);
    chk("vga_line_count", nl, 2);
    chk("vga_vcount_line1", int'(b_vc), 1);

    sb_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
